// File: rtl/pacman_key_encoder.sv
// Pac-Man key encoder: five pushbuttons -> ASCII press/release bytes on a valid/ready stream.
// Latency: raw edge to tx_valid is DEBOUNCE_CYCLES+2 edges after the first synchronizer capture.
// Backpressure: tx_ready low holds tx_data/tx_valid; events beyond FIFO_DEPTH are dropped and flag overflow.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   btn_up/down/left/right/reset  raw asynchronous buttons, 1 = pressed
//   tx_data, tx_valid, tx_ready   byte stream toward the UART transmitter
//   overflow                  sticky, set when an event was discarded on a full FIFO

module pacman_key_encoder_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             full,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  input  logic             rd_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // Fullness uses the count before the edge, so a full FIFO refuses a push
  // even when a pop frees a slot in the same cycle.
  assign full   = (count == FULL_CNT);
  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign push   = wr_vld && !full;
  assign pop    = rd_vld && rd_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Cleared so the stream reads 0x00 straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module pacman_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_reset,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       overflow
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [4:0]    btn_raw;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    stable;
  logic [4:0]    flip;
  logic [4:0]    pending;
  logic [4:0]    pending_dir;
  logic [4:0]    grant;
  logic          grant_vld;
  logic [7:0]    grant_code;
  logic          fifo_full;
  logic [CW-1:0] db_cnt [5];

  // Bit index is the arbitration priority (0 = highest).
  assign btn_raw = {btn_reset, btn_right, btn_left, btn_down, btn_up};

  // Release codes are uppercase; the press code is the same letter lowercase.
  function automatic logic [7:0] key_code(input int idx, input logic press);
    logic [7:0] upper;
    case (idx)
      0:       upper = 8'h57;
      1:       upper = 8'h53;
      2:       upper = 8'h41;
      3:       upper = 8'h44;
      default: upper = 8'h52;
    endcase
    return press ? (upper | 8'h20) : upper;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // The flip happens on the edge where the counter would reach DEBOUNCE_CYCLES.
  always_comb begin
    flip = '0;
    for (int i = 0; i < 5; i++)
      flip[i] = (sync2[i] != stable[i]) && (db_cnt[i] == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      stable <= stable ^ flip;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == stable[i] || flip[i]) db_cnt[i] <= '0;
        else                                  db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end

  // Lowest set bit wins; a key cannot flip again before its grant because
  // the debounce window is longer than the five-key arbitration round.
  assign grant     = pending & (~pending + 5'd1);
  assign grant_vld = |pending;

  always_comb begin
    grant_code = 8'h00;
    for (int i = 0; i < 5; i++)
      if (grant[i]) grant_code = key_code(i, pending_dir[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      pending_dir <= '0;
      overflow    <= 1'b0;
    end else begin
      pending     <= (pending & ~grant) | flip;
      // New stable level after a flip is ~stable: 1 means a press.
      pending_dir <= (pending_dir & ~flip) | (flip & ~stable);
      if (grant_vld && fifo_full) overflow <= 1'b1;
    end
  end

  pacman_key_encoder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (grant_vld),
    .wr_dat (grant_code),
    .full   (fifo_full),
    .rd_vld (tx_valid),
    .rd_dat (tx_data),
    .rd_rdy (tx_ready)
  );
endmodule

// File: doc/pacman_key_encoder.md
# pacman_key_encoder

Converts five active-high board pushbuttons (up/down/left/right/reset) into the Pac-Man ASCII key-event byte stream and feeds it to the UART transmitter over a valid/ready handshake. It is the sending end of the protocol consumed by the game's key decoder: a press sends a lowercase code, a release sends the uppercase code. Each button is synchronized and debounced. Events are serialized through a fixed-priority arbiter into a small FIFO, so simultaneous presses are never merged.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a level change. Must be ≥ 5. Board builds use 1_000_000.
- FIFO_DEPTH, 8: event FIFO entries. Power of two, ≥ 2.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_up, btn_down, btn_left, btn_right, btn_reset  in  1 each  raw asynchronous buttons, 1 = pressed
- tx_data  out  8  ASCII event byte at FIFO head
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  UART transmitter accepts byte
- overflow  out  1  sticky: an event was dropped because the FIFO was full

## Operation
- Key index and codes, in priority order 0..4:
  - up: press 'w' 0x77, release 'W' 0x57
  - down: 's' 0x73 / 'S' 0x53
  - left: 'a' 0x61 / 'A' 0x41
  - right: 'd' 0x64 / 'D' 0x44
  - reset: 'r' 0x72 / 'R' 0x52
- Synchronizer: two flops per button. sync2 is the only input used downstream.
- Debounce, per key:
  - Holds a stable level and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - sync2 == stable: counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES: stable flips, the counter clears, and the key's pending bit sets.
  - pending_dir records the event type: 1 = press, 0 = release.
- Arbiter: each cycle, grant the lowest-index key with pending set, and clear that pending bit.
  - FIFO not full: push the granted code.
  - FIFO full: discard the event and set overflow.
  - One grant per cycle. With DEBOUNCE_CYCLES ≥ 5, a key's pending bit is always granted before that key can flip again.
- FIFO:
  - Circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - tx_valid = (count != 0). tx_data = entry at the read pointer.
  - Pop on tx_valid && tx_ready.
  - Fullness is judged on the pre-edge count: a push while full is dropped even if a pop happens in the same cycle.
  - Push and pop together when not full: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow clears only on rst.

## Timing
- Reset (rst high at an edge) sets:
  - synchronizers, stable levels, counters, pending bits: 0
  - FIFO empty, pointers 0
  - tx_valid = 0, tx_data = 0x00, overflow = 0
- Reset mid-operation discards all queued and pending events.
- A button held through reset is reported as a press after the normal latency.
- Latency, isolated event with empty FIFO. Let edge k be the first edge at which sync1 captures the new raw level.
  - sync2 holds the new level after edge k+1.
  - The counter increments at edges k+2 … k+1+N, where N = DEBOUNCE_CYCLES.
  - stable flips and pending sets at edge k+1+N.
  - The FIFO push happens at edge k+2+N, so tx_valid = 1 from edge k+2+N.
- Bounce: any sync2 sample equal to stable before the counter reaches N restarts the count. No event is produced.
- Handshake: while tx_valid && !tx_ready, tx_data and tx_valid hold constant. Each byte is consumed exactly once, at the edge where both are high.
- Simultaneous events leave the FIFO in priority order, one per consecutive cycle.

## Test plan
- Press btn_up for 40 cycles, then release (N=16). Byte 0x77 appears with tx_valid 18 edges after the sync1 capture; later 0x57 appears. tx_ready held high; exactly two bytes total.
- Raise btn_up and btn_right on the same cycle. Bytes 0x77 then 0x64 arrive on consecutive cycles; overflow stays 0.
- Pulse btn_left high for 10 cycles, then low. No byte is emitted and the counter returns to 0.
- tx_ready held low, then generate 9 single-key events. The first 8 are queued in order, the 9th is dropped, and overflow = 1. After tx_ready goes high, exactly 8 bytes drain, tx_data is stable while stalled, and tx_valid falls after the last byte.
- tx_ready low with 3 bytes queued, then rst for 1 cycle. The next cycle shows tx_valid = 0, overflow = 0, tx_data = 0x00. With btn_down held through reset, 0x73 is emitted afterwards.
- Sustained traffic while the FIFO is partially full, with simultaneous push and pop. Count stays constant and pointers wrap past FIFO_DEPTH-1 to 0 without byte loss or reordering.
